cpu_pc_seq: RTL and testbench
=============================

Name: cpu_pc_seq

Overview:
Program-sequencing stage directly upstream of the CPU data path. It holds the program counter that addresses program memory and advances it every cycle. It executes decoded flow-control commands: jump, conditional jump on the data path's registered Z flag, call and return through a hardware return-address stack, and halt. Its PC output addresses instruction memory, whose decoded fields drive the data path controls (register-file select, ALU op, IN_B select, IMM, accumulator enable).

Parameters:
PC_WIDTH, 8, width of program counter and jump/call target
STACK_DEPTH, 4, number of return-address entries (must be >=1)
SP_WIDTH, 3, stack pointer width; must satisfy 2^SP_WIDTH > STACK_DEPTH
RESET_VECTOR, 0, PC value loaded on reset

Ports:
CLK  input  1  system clock, all state updates on rising edge
RST  input  1  synchronous, active-low reset
EN  input  1  advance enable; 0 = hold all state (stall)
JMP  input  1  unconditional jump to TARGET
JZ  input  1  jump to TARGET if Z=1
JNZ  input  1  jump to TARGET if Z=0
CALL  input  1  push return address, jump to TARGET
RET  input  1  pop return address into PC
HALT  input  1  stop sequencing
TARGET  input  PC_WIDTH  jump/call destination from instruction operand
Z  input  1  registered zero flag from data path status register
PC  output  PC_WIDTH  current program counter (registered)
SP  output  SP_WIDTH  stack occupancy, 0..STACK_DEPTH (registered)
HALTED  output  1  sequencer stopped (registered)
STK_ERR  output  1  sticky stack overflow/underflow flag (registered)

Behaviour:
- Reset: at rising CLK with RST=0: PC=RESET_VECTOR, SP=0, HALTED=0, STK_ERR=0, all stack entries=0. Reset overrides every other input, including an active HALTED state.
- All outputs come straight from registers, with no combinational path from inputs. Control applied in cycle n takes effect on PC at the edge ending cycle n; latency is 1 cycle.
- Hold: if EN=0 or HALTED=1, PC, SP, stack and flags keep their values. HALTED clears only on reset.
- Priority when multiple controls are asserted: HALT > RET > CALL > JMP > (JZ|JNZ) > increment.
- Increment, when no control is asserted: PC <= PC+1 modulo 2^PC_WIDTH. Max value wraps to 0 with no flag.
- JMP: PC <= TARGET.
- Conditional jump: taken = (JZ & Z) | (JNZ & ~Z). If taken, PC <= TARGET, else PC <= PC+1. JZ and JNZ together is therefore always taken.
- Z is sampled on the same edge that updates PC. The Z value used is the status register's current output.
- CALL with SP<STACK_DEPTH: stack[SP] <= PC+1 (modulo wrap), SP <= SP+1, PC <= TARGET.
- CALL with SP=STACK_DEPTH (overflow): stack and SP unchanged, PC holds, STK_ERR <= 1, HALTED <= 1.
- RET with SP>0: PC <= stack[SP-1], SP <= SP-1. The popped entry is not cleared.
- RET with SP=0 (underflow): PC holds, STK_ERR <= 1, HALTED <= 1.
- HALT: HALTED <= 1, PC holds (PC still points at the HALT instruction).
- STK_ERR is sticky until reset.
- Stack is a register array indexed by SP. There is no read-during-write hazard because push and pop are mutually exclusive by priority.

Test Plan:
- Reset/wrap: RST=0 one edge, then EN=1 with no controls for 260 cycles -> PC=0 after reset, counts 0..255, wraps to 0 at cycle 256, SP=0, flags 0.
- Conditional: PC=0x10, TARGET=0x40, JZ=1, Z=1 -> PC=0x40. Repeat with Z=0 -> PC=0x11. Same two cases with JNZ -> PC=0x11 and PC=0x40 respectively.
- Nested call/overflow: CALL at PC=0x05,0x20,0x30,0x40 with TARGETs 0x20,0x30,0x40,0x50 -> SP=4, PC=0x50. Fifth CALL -> PC stays 0x50, SP=4, STK_ERR=1, HALTED=1.
- Return chain/underflow: after 4 pushes, 4 RETs -> PC=0x41,0x31,0x21,0x06 and SP=0. Fifth RET -> PC holds 0x06, STK_ERR=1, HALTED=1.
- Stall/priority: EN=0 with JMP=1 -> PC unchanged. EN=1 with HALT=1 and JMP=1 same cycle -> PC unchanged, HALTED=1. While halted, CALL is ignored and SP is unchanged.
- Reset mid-operation: HALTED=1, STK_ERR=1, SP=3, then RST=0 one edge -> PC=RESET_VECTOR, SP=0, HALTED=0, STK_ERR=0, and the next cycle increments to 1.

Source files
------------

// File: rtl/cpu_pc_seq.sv
// cpu_pc_seq: program-sequencing stage ahead of the CPU data path.
// Holds the program counter and advances it every enabled cycle. Executes jump,
// conditional jump on Z, call/return through a hardware return-address stack, and halt.
//
// Ports:
//   CLK     - system clock, all state updates on the rising edge
//   RST     - synchronous active-low reset
//   EN      - advance enable (0 = stall, hold all state)
//   JMP     - unconditional jump to TARGET
//   JZ/JNZ  - jump to TARGET when Z is 1 / 0
//   CALL    - push PC+1, jump to TARGET
//   RET     - pop return address into PC
//   HALT    - stop sequencing until reset
//   TARGET  - jump/call destination
//   Z       - registered zero flag from the data path
//   PC      - current program counter
//   SP      - stack occupancy, 0..STACK_DEPTH
//   HALTED  - sequencer stopped
//   STK_ERR - sticky stack overflow/underflow flag
module cpu_pc_seq #(
  parameter int unsigned          PC_WIDTH     = 8,
  parameter int unsigned          STACK_DEPTH  = 4,
  parameter int unsigned          SP_WIDTH     = 3,
  parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = '0
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                EN,
  input  logic                JMP,
  input  logic                JZ,
  input  logic                JNZ,
  input  logic                CALL,
  input  logic                RET,
  input  logic                HALT,
  input  logic [PC_WIDTH-1:0] TARGET,
  input  logic                Z,
  output logic [PC_WIDTH-1:0] PC,
  output logic [SP_WIDTH-1:0] SP,
  output logic                HALTED,
  output logic                STK_ERR
);

  localparam logic [SP_WIDTH-1:0] SpFull = SP_WIDTH'(STACK_DEPTH);

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [SP_WIDTH-1:0] sp_q, sp_d;
  logic                halted_q, halted_d;
  logic                err_q, err_d;
  logic [PC_WIDTH-1:0] stack_q [STACK_DEPTH];

  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] ret_addr;
  logic                push;
  logic                cond_taken;

  assign pc_inc     = pc_q + PC_WIDTH'(1);
  assign cond_taken = (JZ & Z) | (JNZ & ~Z);

  // Top-of-stack read; compare-select avoids indexing the array with a wider SP.
  always_comb begin
    ret_addr = '0;
    for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
      if (sp_q == SP_WIDTH'(i + 1)) ret_addr = stack_q[i];
    end
  end

  always_comb begin
    pc_d     = pc_q;
    sp_d     = sp_q;
    halted_d = halted_q;
    err_d    = err_q;
    push     = 1'b0;
    if (EN && !halted_q) begin
      if (HALT) begin
        halted_d = 1'b1;
      end else if (RET) begin
        if (sp_q == '0) begin
          err_d    = 1'b1;
          halted_d = 1'b1;
        end else begin
          pc_d = ret_addr;
          sp_d = sp_q - SP_WIDTH'(1);
        end
      end else if (CALL) begin
        if (sp_q == SpFull) begin
          err_d    = 1'b1;
          halted_d = 1'b1;
        end else begin
          push = 1'b1;
          pc_d = TARGET;
          sp_d = sp_q + SP_WIDTH'(1);
        end
      end else if (JMP || cond_taken) begin
        pc_d = TARGET;
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      pc_q     <= RESET_VECTOR;
      sp_q     <= '0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
      for (int unsigned i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
    end else begin
      pc_q     <= pc_d;
      sp_q     <= sp_d;
      halted_q <= halted_d;
      err_q    <= err_d;
      for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
        if (push && sp_q == SP_WIDTH'(i)) stack_q[i] <= pc_inc;
      end
    end
  end

  assign PC      = pc_q;
  assign SP      = sp_q;
  assign HALTED  = halted_q;
  assign STK_ERR = err_q;

endmodule

// File: tb/tb_cpu_pc_seq.sv
// Self-checking bench for cpu_pc_seq: directed steps followed by random stimulus,
// all compared against a queue-based reference model of the sequencer.
module tb_cpu_pc_seq;

  logic       CLK = 1'b0;
  logic       RST, EN, JMP, JZ, JNZ, CALL, RET, HALT, Z;
  logic [7:0] TARGET;
  logic [7:0] PC;
  logic [2:0] SP;
  logic       HALTED, STK_ERR;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [7:0] m_pc;
  logic [7:0] m_stk[$];
  bit         m_halted, m_err;

  cpu_pc_seq #(
    .PC_WIDTH    (8),
    .STACK_DEPTH (4),
    .SP_WIDTH    (3),
    .RESET_VECTOR(8'h00)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .EN     (EN),
    .JMP    (JMP),
    .JZ     (JZ),
    .JNZ    (JNZ),
    .CALL   (CALL),
    .RET    (RET),
    .HALT   (HALT),
    .TARGET (TARGET),
    .Z      (Z),
    .PC     (PC),
    .SP     (SP),
    .HALTED (HALTED),
    .STK_ERR(STK_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_step();
    if (!RST) begin
      m_pc = 8'h00;
      m_stk.delete();
      m_halted = 1'b0;
      m_err = 1'b0;
    end else if (EN && !m_halted) begin
      if (HALT) begin
        m_halted = 1'b1;
      end else if (RET) begin
        if (m_stk.size() == 0) begin
          m_err = 1'b1;
          m_halted = 1'b1;
        end else begin
          m_pc = m_stk.pop_back();
        end
      end else if (CALL) begin
        if (m_stk.size() == 4) begin
          m_err = 1'b1;
          m_halted = 1'b1;
        end else begin
          m_stk.push_back(8'(m_pc + 1));
          m_pc = TARGET;
        end
      end else if (JMP || (JZ && Z) || (JNZ && !Z)) begin
        m_pc = TARGET;
      end else begin
        m_pc = 8'(m_pc + 1);
      end
    end
  endfunction

  // Advance one clock: model sees the same pre-edge inputs, then compare after the edge.
  task automatic tick();
    model_step();
    @(posedge CLK);
    #1;
    chk("pc", 32'(PC), 32'(m_pc));
    chk("sp", 32'(SP), 32'(m_stk.size()));
    chk("halted", 32'(HALTED), 32'(m_halted));
    chk("stk_err", 32'(STK_ERR), 32'(m_err));
  endtask

  task automatic idle();
    RST = 1'b1; EN = 1'b1; JMP = 1'b0; JZ = 1'b0; JNZ = 1'b0;
    CALL = 1'b0; RET = 1'b0; HALT = 1'b0; Z = 1'b0; TARGET = 8'h00;
  endtask

  task automatic do_reset();
    idle();
    RST = 1'b0;
    tick();
    RST = 1'b1;
  endtask

  task automatic jump_to(input logic [7:0] t);
    idle(); JMP = 1'b1; TARGET = t;
    tick();
    idle();
  endtask

  task automatic call_to(input logic [7:0] t);
    idle(); CALL = 1'b1; TARGET = t;
    tick();
    idle();
  endtask

  task automatic ret_once();
    idle(); RET = 1'b1;
    tick();
    idle();
  endtask

  task automatic cond(input logic jz, input logic jnz, input logic z, input logic [7:0] exp,
                      input string tag);
    jump_to(8'h10);
    idle(); JZ = jz; JNZ = jnz; Z = z; TARGET = 8'h40;
    tick();
    chk(tag, 32'(PC), 32'(exp));
    idle();
  endtask

  initial begin
    idle();
    m_pc = 8'hxx; m_halted = 1'b0; m_err = 1'b0;

    // Reset and free-running wrap
    do_reset();
    chk("reset_pc", 32'(PC), 32'h0);
    chk("reset_sp", 32'(SP), 32'h0);
    chk("reset_flags", 32'({HALTED, STK_ERR}), 32'h0);
    for (int i = 0; i < 260; i++) begin
      tick();
      chk("count", 32'(PC), 32'((i + 1) % 256));
    end
    chk("wrap_flags", 32'({HALTED, STK_ERR}), 32'h0);

    // Conditional jumps
    cond(1'b1, 1'b0, 1'b1, 8'h40, "jz_taken");
    cond(1'b1, 1'b0, 1'b0, 8'h11, "jz_not_taken");
    cond(1'b0, 1'b1, 1'b1, 8'h11, "jnz_not_taken");
    cond(1'b0, 1'b1, 1'b0, 8'h40, "jnz_taken");
    cond(1'b1, 1'b1, 1'b0, 8'h40, "jz_jnz_both");

    // Nested calls and overflow
    jump_to(8'h05);
    call_to(8'h20);
    call_to(8'h30);
    call_to(8'h40);
    call_to(8'h50);
    chk("call4_pc", 32'(PC), 32'h50);
    chk("call4_sp", 32'(SP), 32'h4);
    call_to(8'h60);
    chk("ovf_pc", 32'(PC), 32'h50);
    chk("ovf_sp", 32'(SP), 32'h4);
    chk("ovf_flags", 32'({HALTED, STK_ERR}), 32'h3);

    // Return chain and underflow
    do_reset();
    jump_to(8'h05);
    call_to(8'h20);
    call_to(8'h30);
    call_to(8'h40);
    call_to(8'h50);
    ret_once(); chk("ret1", 32'(PC), 32'h41);
    ret_once(); chk("ret2", 32'(PC), 32'h31);
    ret_once(); chk("ret3", 32'(PC), 32'h21);
    ret_once(); chk("ret4", 32'(PC), 32'h06);
    chk("ret_sp", 32'(SP), 32'h0);
    ret_once();
    chk("unf_pc", 32'(PC), 32'h06);
    chk("unf_flags", 32'({HALTED, STK_ERR}), 32'h3);

    // Stall and priority
    do_reset();
    jump_to(8'h33);
    idle(); EN = 1'b0; JMP = 1'b1; TARGET = 8'h99;
    tick();
    chk("stall_pc", 32'(PC), 32'h33);
    idle(); HALT = 1'b1; JMP = 1'b1; TARGET = 8'h99;
    tick();
    chk("halt_pc", 32'(PC), 32'h33);
    chk("halt_flag", 32'(HALTED), 32'h1);
    idle(); CALL = 1'b1; TARGET = 8'h77;
    tick();
    chk("halted_call_pc", 32'(PC), 32'h33);
    chk("halted_call_sp", 32'(SP), 32'h0);

    // Reset mid-operation from halted with SP=3
    do_reset();
    call_to(8'h10);
    call_to(8'h20);
    call_to(8'h30);
    idle(); HALT = 1'b1;
    tick();
    chk("mid_sp", 32'(SP), 32'h3);
    idle(); RST = 1'b0; CALL = 1'b1;
    tick();
    chk("mid_rst_pc", 32'(PC), 32'h0);
    chk("mid_rst_sp", 32'(SP), 32'h0);
    chk("mid_rst_flags", 32'({HALTED, STK_ERR}), 32'h0);
    idle();
    tick();
    chk("mid_rst_inc", 32'(PC), 32'h1);

    // Randomized stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      RST    = ($urandom_range(99) != 0);
      EN     = ($urandom_range(9) != 0);
      JMP    = ($urandom_range(7) == 0);
      JZ     = ($urandom_range(5) == 0);
      JNZ    = ($urandom_range(5) == 0);
      CALL   = ($urandom_range(5) == 0);
      RET    = ($urandom_range(5) == 0);
      HALT   = ($urandom_range(59) == 0);
      Z      = 1'($urandom_range(1));
      TARGET = 8'($urandom);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
